// File: rtl/sync_exec.sv
// sync_exec: executes one timed gating command. A command is armed on DATA_WR,
// started when TIME reaches TIME_START (within LATE_TOL cycles), runs
// N_impulse periods of blank/impulse gating with an optionally stepped
// frequency word, then pulses REQ_COMM so the writer supplies the next entry.
module sync_exec #(
   parameter int REQ_LEN  = 4,
   parameter int LATE_TOL = 2
) (
   input  logic        CLK,
   input  logic        rst,
   input  logic [63:0] TIME,
   input  logic        SYS_TIME_UPDATE,
   input  logic        DATA_WR,
   input  logic [47:0] FREQ,
   input  logic [47:0] FREQ_STEP,
   input  logic [31:0] FREQ_RATE,
   input  logic [63:0] TIME_START,
   input  logic [15:0] N_impulse,
   input  logic [1:0]  TYPE_impulse,
   input  logic [31:0] Interval_Ti,
   input  logic [31:0] Interval_Tp,
   input  logic [31:0] Tblank1,
   input  logic [31:0] Tblank2,
   output logic        REQ_COMM,
   output logic        IMPULSE,
   output logic        BLANK,
   output logic [47:0] FREQ_OUT,
   output logic        BUSY,
   output logic        ERR
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ARMED = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [31:0] REQ_LAST = 32'(REQ_LEN - 1);

   typedef struct packed {
      logic [47:0] freq;
      logic [47:0] step;
      logic [31:0] rate;
      logic [63:0] start;
      logic [15:0] n;
      logic [1:0]  typ;
      logic [31:0] ti;
      logic [31:0] tp;
      logic [31:0] tb1;
      logic [31:0] tb2;
   } cmd_t;

   cmd_t        cmd_in;
   cmd_t        act;
   cmd_t        pend;
   logic        pend_valid;
   logic [1:0]  state;
   logic [31:0] ph;
   logic [15:0] per;
   logic [31:0] rate_cnt;
   logic [31:0] rq_cnt;

   // The run only uses local counters, so a time reload never needs handling.
   logic sys_time_update_unused;
   assign sys_time_update_unused = SYS_TIME_UPDATE;

   assign cmd_in = {FREQ, FREQ_STEP, FREQ_RATE, TIME_START, N_impulse, TYPE_impulse,
                    Interval_Ti, Interval_Tp, Tblank1, Tblank2};

   // Phase window edges, widened so that large intervals cannot wrap.
   logic [33:0] end_blank1;
   logic [33:0] end_imp;
   logic [33:0] end_all;
   logic [33:0] ph_ext;
   logic        imp_next;
   logic        blank_next;
   logic        ph_last;
   logic        per_last;
   logic [64:0] late_lim;
   logic        time_early;
   logic        time_late;
   logic        cmd_bad;
   logic        stepping;

   assign end_blank1 = {2'b00, act.tb1};
   assign end_imp    = end_blank1 + {2'b00, act.ti};
   assign end_all    = end_imp + {2'b00, act.tb2};
   assign ph_ext     = {2'b00, ph};
   assign imp_next   = (ph_ext >= end_blank1) && (ph_ext < end_imp);
   assign blank_next = (ph_ext < end_blank1) || ((ph_ext >= end_imp) && (ph_ext < end_all));
   assign ph_last    = (ph == act.tp - 32'd1);
   assign per_last   = (per == act.n - 16'd1);
   assign late_lim   = {1'b0, act.start} + 65'(LATE_TOL);
   assign time_early = (TIME < act.start);
   assign time_late  = ({1'b0, TIME} > late_lim);
   assign cmd_bad    = (act.tp == 32'd0) || (end_all > {2'b00, act.tp});
   assign stepping   = ((act.typ == 2'd1) || (act.typ == 2'd2)) && (act.rate != 32'd0);

   assign BUSY = (state == S_ARMED) || (state == S_RUN);

   // Command FSM, run counters and all registered outputs.
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         act        <= '0;
         pend       <= '0;
         pend_valid <= 1'b0;
         ph         <= '0;
         per        <= '0;
         rate_cnt   <= '0;
         rq_cnt     <= '0;
         IMPULSE    <= 1'b0;
         BLANK      <= 1'b0;
         FREQ_OUT   <= '0;
         REQ_COMM   <= 1'b0;
         ERR        <= 1'b0;
      end else begin
         ERR <= 1'b0;
         case (state)
            S_IDLE, S_ARMED: begin
               IMPULSE <= 1'b0;
               BLANK   <= 1'b0;
               if (state == S_IDLE) FREQ_OUT <= '0;
               if (DATA_WR) begin
                  // A newer write replaces any armed command; an empty slot is dropped.
                  act <= cmd_in;
                  if (cmd_in.start == 64'd0) begin
                     state    <= S_IDLE;
                     FREQ_OUT <= '0;
                  end else begin
                     state <= S_ARMED;
                  end
               end else if ((state == S_ARMED) && !time_early) begin
                  if (time_late || cmd_bad) begin
                     ERR      <= 1'b1;
                     state    <= S_DONE;
                     REQ_COMM <= 1'b1;
                     rq_cnt   <= REQ_LAST;
                  end else if (act.n == 16'd0) begin
                     state    <= S_DONE;
                     REQ_COMM <= 1'b1;
                     rq_cnt   <= REQ_LAST;
                  end else begin
                     state <= S_RUN;
                     ph    <= '0;
                     per   <= '0;
                  end
               end
            end
            S_RUN: begin
               if (DATA_WR) begin
                  pend       <= cmd_in;
                  pend_valid <= 1'b1;
               end
               IMPULSE <= imp_next;
               BLANK   <= blank_next;
               // Reload at impulse start, then step every act.rate cycles while gated.
               if (imp_next && (ph == act.tb1)) begin
                  FREQ_OUT <= act.freq;
                  rate_cnt <= 32'd1;
               end else if (imp_next && stepping) begin
                  if (rate_cnt == act.rate) begin
                     FREQ_OUT <= (act.typ == 2'd1) ? FREQ_OUT + act.step : FREQ_OUT - act.step;
                     rate_cnt <= 32'd1;
                  end else begin
                     rate_cnt <= rate_cnt + 32'd1;
                  end
               end
               if (ph_last) begin
                  ph  <= '0;
                  per <= per + 16'd1;
                  if (per_last) begin
                     state    <= S_DONE;
                     REQ_COMM <= 1'b1;
                     rq_cnt   <= REQ_LAST;
                  end
               end else begin
                  ph <= ph + 32'd1;
               end
            end
            S_DONE: begin
               IMPULSE <= 1'b0;
               BLANK   <= 1'b0;
               if (rq_cnt == 32'd0) begin
                  REQ_COMM   <= 1'b0;
                  pend_valid <= 1'b0;
                  if (DATA_WR) begin
                     // Fresh data from the writer supersedes the pending entry.
                     act <= cmd_in;
                     state <= (cmd_in.start == 64'd0) ? S_IDLE : S_ARMED;
                     if (cmd_in.start == 64'd0) FREQ_OUT <= '0;
                  end else if (pend_valid) begin
                     act <= pend;
                     state <= (pend.start == 64'd0) ? S_IDLE : S_ARMED;
                     if (pend.start == 64'd0) FREQ_OUT <= '0;
                  end else begin
                     state    <= S_IDLE;
                     FREQ_OUT <= '0;
                  end
               end else begin
                  rq_cnt <= rq_cnt - 32'd1;
                  if (DATA_WR) begin
                     pend       <= cmd_in;
                     pend_valid <= 1'b1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sync_exec.sv
// tb_sync_exec: directed commands; expected output events are queued when a
// command is issued and a negedge monitor matches every observed edge.
module tb_sync_exec;

   localparam int REQ_LEN = 4;

   localparam int K_BRISE = 0;
   localparam int K_BFALL = 1;
   localparam int K_IRISE = 2;
   localparam int K_IFALL = 3;
   localparam int K_FCHG  = 4;
   localparam int K_ERR   = 5;
   localparam int K_RRISE = 6;
   localparam int K_RFALL = 7;

   logic        CLK;
   logic        rst;
   logic [63:0] TIME;
   logic        SYS_TIME_UPDATE;
   logic        DATA_WR;
   logic [47:0] FREQ;
   logic [47:0] FREQ_STEP;
   logic [31:0] FREQ_RATE;
   logic [63:0] TIME_START;
   logic [15:0] N_impulse;
   logic [1:0]  TYPE_impulse;
   logic [31:0] Interval_Ti;
   logic [31:0] Interval_Tp;
   logic [31:0] Tblank1;
   logic [31:0] Tblank2;
   logic        REQ_COMM;
   logic        IMPULSE;
   logic        BLANK;
   logic [47:0] FREQ_OUT;
   logic        BUSY;
   logic        ERR;

   int checks   = 0;
   int failures = 0;
   bit mon_on   = 0;

   typedef struct {
      int              kind;
      longint unsigned t;
      logic [47:0]     v;
   } ev_t;

   ev_t exp_q[$];

   sync_exec #(.REQ_LEN(REQ_LEN), .LATE_TOL(2)) dut (
      .CLK(CLK), .rst(rst), .TIME(TIME), .SYS_TIME_UPDATE(SYS_TIME_UPDATE),
      .DATA_WR(DATA_WR), .FREQ(FREQ), .FREQ_STEP(FREQ_STEP), .FREQ_RATE(FREQ_RATE),
      .TIME_START(TIME_START), .N_impulse(N_impulse), .TYPE_impulse(TYPE_impulse),
      .Interval_Ti(Interval_Ti), .Interval_Tp(Interval_Tp), .Tblank1(Tblank1),
      .Tblank2(Tblank2), .REQ_COMM(REQ_COMM), .IMPULSE(IMPULSE), .BLANK(BLANK),
      .FREQ_OUT(FREQ_OUT), .BUSY(BUSY), .ERR(ERR)
   );

   initial begin
      CLK = 0;
      forever #5 CLK = ~CLK;
   end

   // Free-running system time, advanced just after each rising edge.
   initial begin
      TIME = 0;
      forever begin
         @(posedge CLK);
         #1;
         TIME = TIME + 64'd1;
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h (TIME=%0d)", name, got, exp, TIME);
      end else begin
         $display("ok   %s = %0h (TIME=%0d)", name, got, TIME);
      end
   endtask

   task automatic push(input int kind, input longint unsigned t, input logic [47:0] v);
      ev_t e;
      e.kind = kind;
      e.t    = t;
      e.v    = v;
      exp_q.push_back(e);
   endtask

   task automatic check_event(input int kind, input string name, input logic [47:0] v);
      int idx;
      idx = -1;
      checks++;
      for (int i = 0; i < exp_q.size(); i++) begin
         if (exp_q[i].kind == kind) begin
            idx = i;
            break;
         end
      end
      if (idx < 0) begin
         failures++;
         $display("FAIL %s: unexpected event at TIME=%0d value=%0h", name, TIME, v);
      end else begin
         if ((exp_q[idx].t != TIME) || (exp_q[idx].v != v)) begin
            failures++;
            $display("FAIL %s: got TIME=%0d value=%0h expected TIME=%0d value=%0h",
                     name, TIME, v, exp_q[idx].t, exp_q[idx].v);
         end else begin
            $display("ok   %s at TIME=%0d value=%0h", name, TIME, v);
         end
         exp_q.delete(idx);
      end
   endtask

   // Monitor: every output edge is matched against the queued expectation.
   initial begin
      logic p_imp, p_blk, p_req;
      logic [47:0] p_freq;
      p_imp = 0; p_blk = 0; p_req = 0; p_freq = '0;
      forever begin
         @(negedge CLK);
         if (mon_on) begin
            if (BLANK && !p_blk)   check_event(K_BRISE, "blank_rise", '0);
            if (!BLANK && p_blk)   check_event(K_BFALL, "blank_fall", '0);
            if (IMPULSE && !p_imp) check_event(K_IRISE, "impulse_rise", FREQ_OUT);
            if (!IMPULSE && p_imp) check_event(K_IFALL, "impulse_fall", '0);
            if (IMPULSE && p_imp && (FREQ_OUT != p_freq)) check_event(K_FCHG, "freq_step", FREQ_OUT);
            if (ERR)               check_event(K_ERR, "err_strobe", '0);
            if (REQ_COMM && !p_req) check_event(K_RRISE, "req_rise", '0);
            if (!REQ_COMM && p_req) check_event(K_RFALL, "req_fall", '0);
         end
         p_imp  = IMPULSE;
         p_blk  = BLANK;
         p_req  = REQ_COMM;
         p_freq = FREQ_OUT;
      end
   end

   // Expected edges for a run whose start compare succeeds while TIME == tc:
   // phase p of period k is visible at TIME tc + 2 + k*tp + p.
   task automatic expect_run(input longint unsigned tc, input int n, input int tp, input int tb1,
                             input int ti, input int tb2, input logic [47:0] freq,
                             input logic [47:0] step, input int rate, input int typ);
      longint unsigned base;
      for (int k = 0; k < n; k++) begin
         base = tc + 64'd2 + 64'(k * tp);
         push(K_BRISE, base, '0);
         push(K_BFALL, base + 64'(tb1), '0);
         push(K_IRISE, base + 64'(tb1), freq);
         push(K_IFALL, base + 64'(tb1 + ti), '0);
         push(K_BRISE, base + 64'(tb1 + ti), '0);
         push(K_BFALL, base + 64'(tb1 + ti + tb2), '0);
         if (((typ == 1) || (typ == 2)) && (rate > 0)) begin
            for (int j = 1; j * rate < ti; j++) begin
               push(K_FCHG, base + 64'(tb1 + j * rate),
                    (typ == 1) ? freq + 48'(j) * step : freq - 48'(j) * step);
            end
         end
      end
      push(K_RRISE, tc + 64'(n * tp) + 64'd1, '0);
      push(K_RFALL, tc + 64'(n * tp) + 64'd1 + 64'(REQ_LEN), '0);
   endtask

   task automatic expect_err(input longint unsigned t);
      push(K_ERR, t, '0);
      push(K_RRISE, t, '0);
      push(K_RFALL, t + 64'(REQ_LEN), '0);
   endtask

   // Issue one command; TIME_START is tcap+off when rel is set, else off.
   task automatic send(input bit rel, input longint off, input int n, input int tp, input int tb1,
                       input int ti, input int tb2, input logic [47:0] freq, input logic [47:0] step,
                       input int rate, input int typ, output longint unsigned tcap);
      @(posedge CLK);
      #2;
      tcap         = TIME;
      TIME_START   = rel ? tcap + 64'(off) : 64'(off);
      N_impulse    = 16'(n);
      Interval_Tp  = 32'(tp);
      Tblank1      = 32'(tb1);
      Interval_Ti  = 32'(ti);
      Tblank2      = 32'(tb2);
      FREQ         = freq;
      FREQ_STEP    = step;
      FREQ_RATE    = 32'(rate);
      TYPE_impulse = 2'(typ);
      DATA_WR      = 1;
      @(posedge CLK);
      #2;
      DATA_WR = 0;
   endtask

   task automatic wait_time(input longint unsigned t);
      while (TIME < t) begin
         @(posedge CLK);
         #2;
      end
   endtask

   initial begin
      longint unsigned t1, t2, tc1, tc2;
      bit req_seen;
      rst = 1; DATA_WR = 0; SYS_TIME_UPDATE = 0;
      FREQ = '0; FREQ_STEP = '0; FREQ_RATE = '0; TIME_START = '0; N_impulse = '0;
      TYPE_impulse = '0; Interval_Ti = '0; Interval_Tp = '0; Tblank1 = '0; Tblank2 = '0;
      repeat (3) @(posedge CLK);
      #2;
      check("reset_req", 64'(REQ_COMM), 0);
      check("reset_impulse", 64'(IMPULSE), 0);
      check("reset_blank", 64'(BLANK), 0);
      check("reset_freq", 64'(FREQ_OUT), 0);
      check("reset_busy", 64'(BUSY), 0);
      check("reset_err", 64'(ERR), 0);
      rst = 0;
      @(posedge CLK);
      #2;
      check("idle_busy", 64'(BUSY), 0);
      mon_on = 1;

      // Basic CW run at TIME_START=1000 with a SYS_TIME_UPDATE blip mid-run.
      wait_time(980);
      send(0, 1000, 2, 100, 5, 20, 5, 48'h1000, 48'h0, 0, 0, t1);
      check("busy_armed", 64'(BUSY), 1);
      expect_run(1000, 2, 100, 5, 20, 5, 48'h1000, 48'h0, 0, 0);
      wait_time(1050);
      SYS_TIME_UPDATE = 1;
      @(posedge CLK);
      #2;
      SYS_TIME_UPDATE = 0;
      wait_time(1215);
      check("busy_after_done", 64'(BUSY), 0);
      check("freq_idle", 64'(FREQ_OUT), 0);

      // LFM up, two periods so the reload is observed.
      send(1, 10, 2, 40, 3, 16, 3, 48'd100, 48'd10, 4, 1, t1);
      expect_run(t1 + 10, 2, 40, 3, 16, 3, 48'd100, 48'd10, 4, 1);
      wait_time(t1 + 10 + 80 + 10);
      check("freq_idle_lfm", 64'(FREQ_OUT), 0);

      // LFM down.
      send(1, 10, 1, 40, 3, 16, 3, 48'd100, 48'd10, 4, 2, t1);
      expect_run(t1 + 10, 1, 40, 3, 16, 3, 48'd100, 48'd10, 4, 2);
      wait_time(t1 + 10 + 40 + 10);

      // Late start, then the late-tolerance boundary on both sides.
      send(1, -10, 1, 10, 1, 2, 1, 48'd5, 48'd0, 0, 0, t1);
      expect_err(t1 + 2);
      wait_time(t1 + 12);
      send(1, -2, 1, 10, 1, 2, 1, 48'd6, 48'd0, 0, 0, t1);
      expect_err(t1 + 2);
      wait_time(t1 + 12);
      send(1, -1, 1, 10, 1, 2, 1, 48'd7, 48'd0, 0, 0, t1);
      expect_run(t1 + 1, 1, 10, 1, 2, 1, 48'd7, 48'd0, 0, 0);
      wait_time(t1 + 1 + 10 + 10);

      // Re-arm: the second write replaces the first; nothing happens at the first start.
      send(1, 200, 1, 20, 2, 5, 2, 48'h2000, 48'd0, 0, 0, t1);
      send(1, 50, 1, 20, 2, 5, 2, 48'h2100, 48'd0, 0, 0, t2);
      check("busy_rearmed", 64'(BUSY), 1);
      expect_run(t2 + 50, 1, 20, 2, 5, 2, 48'h2100, 48'd0, 0, 0);
      wait_time(t1 + 200 + 30);
      check("busy_after_rearm", 64'(BUSY), 0);

      // Empty slot written over an armed command disarms it.
      send(1, 40, 1, 20, 2, 5, 2, 48'h2200, 48'd0, 0, 0, t1);
      check("busy_before_discard", 64'(BUSY), 1);
      send(0, 0, 1, 20, 2, 5, 2, 48'h2300, 48'd0, 0, 0, t2);
      check("busy_discarded", 64'(BUSY), 0);
      wait_time(t1 + 70);

      // Pending command captured mid-run executes after REQ_COMM.
      send(1, 10, 2, 30, 2, 10, 2, 48'h3000, 48'd0, 0, 0, t1);
      tc1 = t1 + 10;
      expect_run(tc1, 2, 30, 2, 10, 2, 48'h3000, 48'd0, 0, 0);
      wait_time(tc1 + 20);
      send(1, 60, 1, 30, 2, 10, 2, 48'h4000, 48'd0, 0, 0, t2);
      tc2 = t2 + 60;
      expect_run(tc2, 1, 30, 2, 10, 2, 48'h4000, 48'd0, 0, 0);
      wait_time(tc1 + 70);
      check("busy_pending_armed", 64'(BUSY), 1);
      wait_time(tc2 + 30 + 10);

      // N_impulse == 0: REQ_COMM only.
      send(1, 5, 0, 10, 1, 2, 1, 48'h11, 48'd0, 0, 0, t1);
      push(K_RRISE, t1 + 6, '0);
      push(K_RFALL, t1 + 6 + 64'(REQ_LEN), '0);
      wait_time(t1 + 15);

      // Gates overrun the period by one cycle, then a zero period.
      send(1, 5, 1, 10, 3, 5, 3, 48'h12, 48'd0, 0, 0, t1);
      expect_err(t1 + 6);
      wait_time(t1 + 15);
      send(1, 5, 1, 0, 0, 0, 0, 48'h13, 48'd0, 0, 0, t1);
      expect_err(t1 + 6);
      wait_time(t1 + 15);

      // Reset during an impulse drops every gate at once and sends no REQ_COMM.
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL expect_queue_drained: got %0d pending, expected 0 (first kind %0d at TIME=%0d)",
                  exp_q.size(), exp_q[0].kind, exp_q[0].t);
      end else begin
         $display("ok   expect_queue_drained");
      end
      mon_on = 0;
      send(1, 5, 1, 200, 2, 150, 2, 48'h55, 48'd0, 0, 0, t1);
      for (int i = 0; i < 50 && !IMPULSE; i++) begin
         @(posedge CLK);
         #2;
      end
      check("impulse_before_reset", 64'(IMPULSE), 1);
      repeat (10) @(posedge CLK);
      #2;
      rst = 1;
      #1;
      check("rst_impulse", 64'(IMPULSE), 0);
      check("rst_blank", 64'(BLANK), 0);
      check("rst_freq", 64'(FREQ_OUT), 0);
      check("rst_busy", 64'(BUSY), 0);
      @(posedge CLK);
      #2;
      rst = 0;
      req_seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge CLK);
         if (REQ_COMM || IMPULSE || BLANK) req_seen = 1;
      end
      check("no_activity_after_reset", 64'(req_seen), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
